// File: rtl/irom_loader_if.sv
// irom_loader_if: instruction-ROM write bus between the loader and the ROM.
//   rom_we    - one-cycle write strobe per 32-bit word
//   rom_addr  - word address, valid while rom_we=1
//   rom_wdata - instruction word, valid while rom_we=1
interface irom_loader_if #(parameter int ADDR_W = 10);
    logic              rom_we;
    logic [ADDR_W-1:0] rom_addr;
    logic [31:0]       rom_wdata;
    modport master (output rom_we, rom_addr, rom_wdata);
    modport slave  (input  rom_we, rom_addr, rom_wdata);
endinterface

// File: rtl/irom_loader.sv
// irom_loader: UART 8N1 boot loader that fills the instruction ROM, then releases the CPU.
//   clk       - sole clock
//   rst_n     - asynchronous active-low reset
//   uart_rx   - asynchronous serial input, idle high
//   rom       - ROM write bus (rom_we / rom_addr / rom_wdata)
//   cpu_rst_n - registered CPU reset, high only after a successful load
//   busy      - load in progress (header received, not yet DONE/ERROR)
//   err       - sticky error flag, cleared only by reset
module irom_loader #(
    parameter int CLK_DIV = 16,
    parameter int ADDR_W  = 10
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           uart_rx,
    irom_loader_if.master  rom,
    output logic           cpu_rst_n,
    output logic           busy,
    output logic           err
);
    localparam logic [2:0] IDLE = 3'd0, HDR_LO = 3'd1, HDR_HI = 3'd2, WORD = 3'd3,
                           WRITE = 3'd4, DONE = 3'd5, ERROR = 3'd6;
    localparam logic [15:0] HALF = 16'(CLK_DIV / 2 - 1);
    localparam logic [15:0] FULL = 16'(CLK_DIV - 1);

    logic              s1_q, s2_q, s3_q;
    logic              rx_on_q, bv_q, ferr_q;
    logic [15:0]       tick_q;
    logic [3:0]        bit_q;
    logic [7:0]        sh_q;
    logic [2:0]        state_q, state_d;
    logic [15:0]       cnt_q, widx_q, hdr;
    logic [1:0]        bc_q;
    logic [23:0]       asm_q;
    logic              cpu_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;

    // bit_q: 0 = start bit, 1..8 = data bits, 9 = stop bit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q    <= 1'b1;
            s2_q    <= 1'b1;
            s3_q    <= 1'b1;
            rx_on_q <= 1'b0;
            bv_q    <= 1'b0;
            ferr_q  <= 1'b0;
            tick_q  <= '0;
            bit_q   <= '0;
            sh_q    <= '0;
        end else begin
            s1_q   <= uart_rx;
            s2_q   <= s1_q;
            s3_q   <= s2_q;
            bv_q   <= 1'b0;
            ferr_q <= 1'b0;
            if (!rx_on_q) begin
                if (s3_q && !s2_q) begin
                    rx_on_q <= 1'b1;
                    tick_q  <= '0;
                    bit_q   <= '0;
                end
            end else if (tick_q == (bit_q == 4'd0 ? HALF : FULL)) begin
                tick_q <= '0;
                bit_q  <= bit_q + 4'd1;
                if (bit_q == 4'd0 && s2_q) rx_on_q <= 1'b0;
                else if (bit_q == 4'd9) begin
                    rx_on_q <= 1'b0;
                    bv_q    <= s2_q;
                    ferr_q  <= !s2_q;
                end else if (bit_q != 4'd0) sh_q <= {s2_q, sh_q[7:1]};
            end else tick_q <= tick_q + 16'd1;
        end
    end

    assign hdr = {sh_q, cnt_q[7:0]};

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, HDR_LO: state_d = bv_q ? HDR_HI : state_q;
            HDR_HI:       state_d = !bv_q ? state_q : hdr == 16'd0 ? DONE :
                                    {1'b0, hdr} > (17'd1 << ADDR_W) ? ERROR : WORD;
            WORD:         state_d = (bv_q && bc_q == 2'd3) ? WRITE : state_q;
            WRITE:        state_d = (widx_q + 16'd1 == cnt_q) ? DONE : WORD;
            default:      state_d = state_q;
        endcase
        if (ferr_q && state_q != DONE) state_d = ERROR;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            widx_q  <= '0;
            bc_q    <= '0;
            asm_q   <= '0;
            cpu_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cpu_q   <= state_d == DONE;
            if (bv_q && (state_q == IDLE || state_q == HDR_LO)) cnt_q[7:0] <= sh_q;
            if (bv_q && state_q == HDR_HI) cnt_q[15:8] <= sh_q;
            if (bv_q && state_q == WORD) begin
                bc_q <= bc_q + 2'd1;
                if (bc_q == 2'd3) begin
                    wdata_q <= {sh_q, asm_q};
                    addr_q  <= widx_q[ADDR_W-1:0];
                end else asm_q[{bc_q, 3'b000} +: 8] <= sh_q;
            end
            if (state_q == WRITE) widx_q <= widx_q + 16'd1;
        end
    end

    assign rom.rom_we    = state_q == WRITE;
    assign rom.rom_addr  = addr_q;
    assign rom.rom_wdata = wdata_q;
    assign cpu_rst_n     = cpu_q;
    assign busy          = state_q == HDR_HI || state_q == WORD || state_q == WRITE;
    assign err           = state_q == ERROR;
endmodule

// File: tb/tb_irom_loader.sv
// tb_irom_loader: directed self-checking bench for irom_loader (CLK_DIV=16, ADDR_W=3).
module tb_irom_loader;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic uart_rx = 1'b1;
    logic cpu_rst_n, busy, err;
    int checks = 0;
    int errors = 0;
    int nw = 0;
    logic [2:0]  la [16];
    logic [31:0] ld [16];

    irom_loader_if #(.ADDR_W(3)) bus ();
    irom_loader #(.CLK_DIV(16), .ADDR_W(3)) dut (
        .clk(clk), .rst_n(rst_n), .uart_rx(uart_rx), .rom(bus),
        .cpu_rst_n(cpu_rst_n), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst_n && bus.rom_we) begin
            if (nw < 16) begin
                la[nw] = bus.rom_addr;
                ld[nw] = bus.rom_wdata;
            end
            nw++;
        end
    end

    task automatic send_byte(input logic [7:0] b, input logic stop);
        @(negedge clk) uart_rx = 1'b0;
        repeat (16) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (16) @(negedge clk);
        end
        uart_rx = stop;
        repeat (16) @(negedge clk);
        uart_rx = 1'b1;
        repeat (6) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        uart_rx = 1'b1;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        do_reset();
        send_byte(8'h05, 1'b1);
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL pre_reset_busy got %b want 1", busy); end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.rom_we, bus.rom_addr, bus.rom_wdata, cpu_rst_n, busy, err} !== 39'd0) begin
            errors++;
            $display("FAIL async_reset got we=%b addr=%h data=%h cpu=%b busy=%b err=%b want all 0",
                     bus.rom_we, bus.rom_addr, bus.rom_wdata, cpu_rst_n, busy, err);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_two_words();
        int base;
        do_reset();
        base = nw;
        send_byte(8'h02, 1'b1);
        send_byte(8'h00, 1'b1);
        checks++;
        if (busy !== 1'b1 || cpu_rst_n !== 1'b0) begin
            errors++; $display("FAIL two_hdr busy=%b cpu=%b want 1 0", busy, cpu_rst_n);
        end
        foreach (ld[k]) ld[k] = 32'hx;
        send_byte(8'h13, 1'b1); send_byte(8'h05, 1'b1);
        send_byte(8'h10, 1'b1); send_byte(8'h00, 1'b1);
        send_byte(8'h73, 1'b1); send_byte(8'h00, 1'b1);
        send_byte(8'h10, 1'b1); send_byte(8'h00, 1'b1);
        checks++;
        if (nw - base !== 2) begin errors++; $display("FAIL two_count got %0d want 2", nw - base); end
        checks++;
        if (la[base] !== 3'd0 || ld[base] !== 32'h00100513) begin
            errors++; $display("FAIL two_w0 got %h:%h want 0:00100513", la[base], ld[base]);
        end
        checks++;
        if (la[base+1] !== 3'd1 || ld[base+1] !== 32'h00100073) begin
            errors++; $display("FAIL two_w1 got %h:%h want 1:00100073", la[base+1], ld[base+1]);
        end
        checks++;
        if (cpu_rst_n !== 1'b1 || busy !== 1'b0 || err !== 1'b0) begin
            errors++; $display("FAIL two_done cpu=%b busy=%b err=%b want 1 0 0", cpu_rst_n, busy, err);
        end
        checks++;
        if (bus.rom_addr !== 3'd1 || bus.rom_wdata !== 32'h00100073) begin
            errors++; $display("FAIL two_hold got %h:%h want 1:00100073", bus.rom_addr, bus.rom_wdata);
        end
        send_byte(8'h55, 1'b0);
        send_byte(8'h01, 1'b1);
        checks++;
        if (err !== 1'b0 || cpu_rst_n !== 1'b1 || busy !== 1'b0 || nw - base !== 2) begin
            errors++; $display("FAIL done_ignore err=%b cpu=%b busy=%b writes=%0d want 0 1 0 2",
                               err, cpu_rst_n, busy, nw - base);
        end
    endtask

    task automatic test_zero_count();
        int base;
        do_reset();
        base = nw;
        send_byte(8'h00, 1'b1);
        checks++;
        if (cpu_rst_n !== 1'b0 || busy !== 1'b1) begin
            errors++; $display("FAIL zero_mid cpu=%b busy=%b want 0 1", cpu_rst_n, busy);
        end
        send_byte(8'h00, 1'b1);
        checks++;
        if (cpu_rst_n !== 1'b1 || busy !== 1'b0 || nw != base) begin
            errors++; $display("FAIL zero_done cpu=%b busy=%b writes=%0d want 1 0 0", cpu_rst_n, busy, nw - base);
        end
    endtask

    task automatic test_oversize();
        int base;
        do_reset();
        base = nw;
        send_byte(8'h09, 1'b1);
        send_byte(8'h00, 1'b1);
        checks++;
        if (err !== 1'b1 || cpu_rst_n !== 1'b0 || busy !== 1'b0 || nw != base) begin
            errors++; $display("FAIL oversize err=%b cpu=%b busy=%b writes=%0d want 1 0 0 0",
                               err, cpu_rst_n, busy, nw - base);
        end
        do_reset();
        send_byte(8'h08, 1'b1);
        send_byte(8'h00, 1'b1);
        checks++;
        if (err !== 1'b0 || busy !== 1'b1) begin
            errors++; $display("FAIL max_count err=%b busy=%b want 0 1", err, busy);
        end
    endtask

    task automatic test_glitch();
        do_reset();
        @(negedge clk) uart_rx = 1'b0;
        repeat (4) @(negedge clk);
        uart_rx = 1'b1;
        repeat (200) @(negedge clk);
        checks++;
        if (err !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL glitch err=%b busy=%b want 0 0", err, busy);
        end
        send_byte(8'h01, 1'b1);
        checks++;
        if (busy !== 1'b1 || err !== 1'b0) begin
            errors++; $display("FAIL glitch_after busy=%b err=%b want 1 0", busy, err);
        end
        send_byte(8'h00, 1'b1);
        checks++;
        if (busy !== 1'b1 || cpu_rst_n !== 1'b0) begin
            errors++; $display("FAIL glitch_count1 busy=%b cpu=%b want 1 0", busy, cpu_rst_n);
        end
    endtask

    task automatic test_frame_err();
        int base;
        do_reset();
        base = nw;
        send_byte(8'h01, 1'b1); send_byte(8'h00, 1'b1);
        send_byte(8'h11, 1'b1); send_byte(8'h22, 1'b1);
        send_byte(8'h33, 1'b0);
        checks++;
        if (err !== 1'b1 || busy !== 1'b0 || cpu_rst_n !== 1'b0) begin
            errors++; $display("FAIL frame_err err=%b busy=%b cpu=%b want 1 0 0", err, busy, cpu_rst_n);
        end
        send_byte(8'h44, 1'b1);
        send_byte(8'h00, 1'b1);
        checks++;
        if (err !== 1'b1 || cpu_rst_n !== 1'b0 || nw != base) begin
            errors++; $display("FAIL frame_sticky err=%b cpu=%b writes=%0d want 1 0 0", err, cpu_rst_n, nw - base);
        end
    endtask

    task automatic test_reset_mid_load();
        int base;
        do_reset();
        base = nw;
        send_byte(8'h02, 1'b1); send_byte(8'h00, 1'b1);
        send_byte(8'hAA, 1'b1); send_byte(8'hBB, 1'b1);
        send_byte(8'hCC, 1'b1); send_byte(8'hDD, 1'b1);
        checks++;
        if (nw - base !== 1 || busy !== 1'b1) begin
            errors++; $display("FAIL mid_first writes=%0d busy=%b want 1 1", nw - base, busy);
        end
        do_reset();
        checks++;
        if (bus.rom_addr !== 3'd0 || cpu_rst_n !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL mid_reset addr=%h cpu=%b busy=%b want 0 0 0", bus.rom_addr, cpu_rst_n, busy);
        end
        base = nw;
        send_byte(8'h01, 1'b1); send_byte(8'h00, 1'b1);
        send_byte(8'hEF, 1'b1); send_byte(8'hBE, 1'b1);
        send_byte(8'hAD, 1'b1); send_byte(8'hDE, 1'b1);
        checks++;
        if (nw - base !== 1 || la[base] !== 3'd0 || ld[base] !== 32'hDEADBEEF) begin
            errors++; $display("FAIL reload writes=%0d got %h:%h want 1 0:deadbeef", nw - base, la[base], ld[base]);
        end
        checks++;
        if (cpu_rst_n !== 1'b1 || err !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL reload_done cpu=%b err=%b busy=%b want 1 0 0", cpu_rst_n, err, busy);
        end
    endtask

    initial begin
        test_reset();
        test_two_words();
        test_zero_count();
        test_oversize();
        test_glitch();
        test_frame_err();
        test_reset_mid_load();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
